text_buffer: RTL and testbench
==============================

Name: text_buffer

Overview:
Parametrised multi-row character buffer, the next generation of the single-line string RAM. Holds ROWS lines of COLS characters, each DATA_WIDTH bits wide, behind a write cursor. Supports append, newline, backspace-with-erase and full-buffer clear sweeps. The display/readout logic reads it through an independent row/column read port.

Parameters:
DATA_WIDTH, 8, character width in bits
COLS, 80, characters per row (≥2)
ROWS, 4, rows in buffer (≥1)
DEPTH, COLS*ROWS, derived; total cells
AW, $clog2(DEPTH), derived; flat address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
wr_en  in  1  append wr_char at cursor
wr_char  in  DATA_WIDTH  character to append
newline  in  1  move cursor to column 0 of next row
back  in  1  backspace: step cursor back one cell and erase it
clear_req  in  1  start full-buffer clear sweep
rd_row  in  $clog2(ROWS)  read row
rd_col  in  $clog2(COLS)  read column
rd_data  out  DATA_WIDTH  read data, 1-cycle latency
cursor_row  out  $clog2(ROWS)  current cursor row
cursor_col  out  $clog2(COLS)  current cursor column
clearing  out  1  high while in CLEAR state
clear_done  out  1  1-cycle pulse on last sweep write
full  out  1  cursor past last cell; appends blocked
overflow  out  1  1-cycle pulse when an append/newline is rejected

Behaviour:
- Reset (rst low, async): state=CLEAR, sweep_addr=0, cursor=(0,0), full=0, overflow=0, clear_done=0. rd_data is undefined until the first read.
- States:
  - CLEAR: each cycle writes 0 to sweep_addr, then increments it. On sweep_addr==DEPTH-1: pulse clear_done, go to SAVE, cursor=(0,0), full=0.
  - SAVE: services commands, one per cycle, in priority order clear_req > back > newline > wr_en. Lower-priority commands in the same cycle are dropped; overflow is not pulsed for them.
- clear_req in SAVE: next state CLEAR, sweep_addr=0. clear_req in CLEAR restarts the sweep at 0. All other inputs are ignored in CLEAR.
- wr_en (SAVE, !full): write wr_char at row*COLS+col.
  - col<COLS-1: col+1.
  - col==COLS-1 and row<ROWS-1: next row, col 0.
  - Last cell: set full, cursor holds.
- wr_en when full: no write; pulse overflow.
- newline (SAVE):
  - row<ROWS-1: row+1, col 0; full stays 0.
  - Last row: no move; pulse overflow.
- back (SAVE):
  - If full: clear full, cursor stays at last cell, write 0 there.
  - Else if col>0: col-1, write 0 at the new position.
  - Else if row>0: row-1, col COLS-1, write 0 there.
  - At (0,0): no-op.
- Write port: exactly one write per cycle at most. Address and data are muxed combinationally from state and command; writes are registered in the RAM.
- Read port: flat address rd_row*COLS+rd_col, registered output, 1-cycle latency. Read and write of the same address in the same cycle returns old data. Out-of-range rd_row/rd_col (non-power-of-2 sizes) returns undefined data and has no side effect.
- Arithmetic: all address products are computed at AW width, never truncated. Cursor counters never wrap.

Decomposition:
- Shared package text_pkg: state enum {SAVE, CLEAR} (1-bit logic) and an address-width helper function.
- Memory uses the existing simple_dual_port_ram_single_clock (DATA_WIDTH, ADDR_WIDTH=AW) as the single sub-module.
- Control FSM and cursor live in text_buffer itself.

Test Plan:
- Reset then idle, COLS=80, ROWS=4 -> clearing high 320 cycles; clear_done pulses once; all reads return 0; cursor (0,0).
- Append 81 chars 'A'..: 80 then 'Q' -> cell (0,79)=last of row 0; 'Q' lands at (1,0); cursor (1,1).
- Fill all 320 cells, then one more wr_en -> full=1, overflow 1-cycle pulse, cell (3,79) unchanged.
- Cursor (1,0) after row 0 full, back -> cursor (0,79), read (0,79)=0. back at (0,0) -> no change.
- newline on row 3 -> overflow pulse, cursor unchanged. newline on row 1 col 5 -> cursor (2,0).
- clear_req with wr_en and back in the same cycle -> CLEAR entered, no char written. clear_req again mid-sweep -> sweep restarts; clear_done fires 320 cycles after the last request. rst low mid-sweep -> immediate CLEAR, sweep_addr 0.

Source files
------------

// File: rtl/text_pkg.sv
// Shared types and sizing helpers for the multi-row text buffer.
package text_pkg;

    typedef enum logic {
        SAVE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Width of an index into n items; a single item still gets one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/text_buffer_if.sv
// Command, read-port and status bundle between the text buffer and its user.
interface text_buffer_if import text_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 80,
    parameter int ROWS       = 4
);
    localparam int RW = addr_w(ROWS);
    localparam int CW = addr_w(COLS);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_char;
    logic                  newline;
    logic                  back;
    logic                  clear_req;
    logic [RW-1:0]         rd_row;
    logic [CW-1:0]         rd_col;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [RW-1:0]         cursor_row;
    logic [CW-1:0]         cursor_col;
    logic                  clearing;
    logic                  clear_done;
    logic                  full;
    logic                  overflow;

    modport master (
        output wr_en, wr_char, newline, back, clear_req, rd_row, rd_col,
        input  rd_data, cursor_row, cursor_col, clearing, clear_done, full, overflow
    );

    modport slave (
        input  wr_en, wr_char, newline, back, clear_req, rd_row, rd_col,
        output rd_data, cursor_row, cursor_col, clearing, clear_done, full, overflow
    );

endinterface

// File: rtl/simple_dual_port_ram_single_clock.sv
// One write port, one registered read port, one clock; a same-address
// read and write in the same cycle returns the old contents.
module simple_dual_port_ram_single_clock #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            ram[write_addr] <= data;
        q <= ram[read_addr];
    end

endmodule

// File: rtl/text_buffer.sv
// ROWS x COLS character buffer behind a write cursor, with append, newline,
// erase-backspace and a full-buffer zeroing sweep; independent read port.
module text_buffer import text_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 80,
    parameter int ROWS       = 4,
    parameter int DEPTH      = COLS * ROWS,
    parameter int AW         = addr_w(DEPTH)
) (
    input logic          clk,
    input logic          rst,
    text_buffer_if.slave bus
);

    localparam int RW = addr_w(ROWS);
    localparam int CW = addr_w(COLS);

    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);

    state_e                state, state_nxt;
    logic [AW-1:0]         sweep_addr, sweep_nxt;
    logic [RW-1:0]         row, row_nxt;
    logic [CW-1:0]         col, col_nxt;
    logic                  full, full_nxt;
    logic                  overflow, overflow_nxt;
    logic                  clear_done, clear_done_nxt;

    logic                  we;
    logic [AW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [AW-1:0]         raddr;

    // Flat cell index, widened to AW before the multiply so it never truncates.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                                input logic [CW-1:0] c);
        return AW'(r) * COLS_A + AW'(c);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= CLEAR;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_addr <= '0;
            row        <= '0;
            col        <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            sweep_addr <= sweep_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            full       <= full_nxt;
            overflow   <= overflow_nxt;
            clear_done <= clear_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sweep_nxt      = sweep_addr;
        row_nxt        = row;
        col_nxt        = col;
        full_nxt       = full;
        overflow_nxt   = 1'b0;
        clear_done_nxt = 1'b0;
        we             = 1'b0;
        waddr          = cell_addr(row, col);
        wdata          = '0;

        case (state)
            CLEAR: begin
                we    = 1'b1;
                waddr = sweep_addr;
                if (bus.clear_req) begin
                    sweep_nxt = '0;
                end else if (sweep_addr == LAST_ADDR) begin
                    clear_done_nxt = 1'b1;
                    state_nxt      = SAVE;
                    row_nxt        = '0;
                    col_nxt        = '0;
                    full_nxt       = 1'b0;
                end else begin
                    sweep_nxt = sweep_addr + AW'(1);
                end
            end

            SAVE: begin
                // One command per cycle; lower-priority ones are simply dropped.
                if (bus.clear_req) begin
                    state_nxt = CLEAR;
                    sweep_nxt = '0;
                end else if (bus.back) begin
                    if (full) begin
                        full_nxt = 1'b0;
                        we       = 1'b1;
                    end else if (col != '0) begin
                        col_nxt = col - CW'(1);
                        we      = 1'b1;
                        waddr   = cell_addr(row, col - CW'(1));
                    end else if (row != '0) begin
                        row_nxt = row - RW'(1);
                        col_nxt = LAST_COL;
                        we      = 1'b1;
                        waddr   = cell_addr(row - RW'(1), LAST_COL);
                    end
                end else if (bus.newline) begin
                    if (row != LAST_ROW) begin
                        row_nxt = row + RW'(1);
                        col_nxt = '0;
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end else if (bus.wr_en) begin
                    if (full) begin
                        overflow_nxt = 1'b1;
                    end else begin
                        we    = 1'b1;
                        wdata = bus.wr_char;
                        if (col != LAST_COL) begin
                            col_nxt = col + CW'(1);
                        end else if (row != LAST_ROW) begin
                            row_nxt = row + RW'(1);
                            col_nxt = '0;
                        end else begin
                            full_nxt = 1'b1;
                        end
                    end
                end
            end

            default: state_nxt = CLEAR;
        endcase
    end

    assign raddr = cell_addr(bus.rd_row, bus.rd_col);

    simple_dual_port_ram_single_clock #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk        (clk),
        .we         (we),
        .write_addr (waddr),
        .read_addr  (raddr),
        .data       (wdata),
        .q          (bus.rd_data)
    );

    assign bus.cursor_row = row;
    assign bus.cursor_col = col;
    assign bus.clearing   = (state == CLEAR);
    assign bus.clear_done = clear_done;
    assign bus.full       = full;
    assign bus.overflow   = overflow;

endmodule

// File: tb/tb_text_buffer.sv
// Directed and randomized bench for text_buffer, checked against a
// linear-cursor reference model of the buffer contents.
module tb_text_buffer;

    localparam int DW    = 8;
    localparam int COLS  = 80;
    localparam int ROWS  = 4;
    localparam int DEPTH = COLS * ROWS;
    localparam int RW    = text_pkg::addr_w(ROWS);
    localparam int CW    = text_pkg::addr_w(COLS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    text_buffer_if #(.DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS)) bus ();

    text_buffer #(.DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: contents plus a linear cursor position.
    logic [DW-1:0] mem [DEPTH];
    int            pos;
    bit            mfull;

    int n_assert;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        pos   = 0;
        mfull = 0;
    endtask

    task automatic cmd(input bit wr, input logic [DW-1:0] ch, input bit nl,
                       input bit bk, input bit clr);
        bit exp_ovf = 0;
        bus.wr_en     = wr;
        bus.wr_char   = ch;
        bus.newline   = nl;
        bus.back      = bk;
        bus.clear_req = clr;
        @(posedge clk); #1;
        bus.wr_en     = 0;
        bus.newline   = 0;
        bus.back      = 0;
        bus.clear_req = 0;
        if (clr) begin
            model_reset();
        end else if (bk) begin
            if (mfull) begin
                mfull    = 0;
                mem[pos] = '0;
            end else if (pos > 0) begin
                pos--;
                mem[pos] = '0;
            end
        end else if (nl) begin
            if (pos / COLS == ROWS - 1) exp_ovf = 1;
            else pos = (pos / COLS + 1) * COLS;
        end else if (wr) begin
            if (mfull) exp_ovf = 1;
            else begin
                mem[pos] = ch;
                if (pos == DEPTH - 1) mfull = 1;
                else pos++;
            end
        end
        chk("overflow", bus.overflow, exp_ovf);
        if (clr) begin
            chk("clearing_on_req", bus.clearing, 1);
        end else begin
            chk("cursor_row", bus.cursor_row, pos / COLS);
            chk("cursor_col", bus.cursor_col, pos % COLS);
            chk("full", bus.full, mfull);
        end
    endtask

    task automatic wait_clear(input string tag, input int exp_cycles);
        int cyc = 0;
        int dones = 0;
        while (bus.clearing === 1'b1 && cyc < 2 * DEPTH + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.clear_done === 1'b1) dones++;
        end
        chk({tag, "_sweep_cycles"}, cyc, exp_cycles);
        chk({tag, "_done_pulses"}, dones, 1);
        @(posedge clk); #1;
        chk({tag, "_done_low"}, bus.clear_done, 0);
        chk({tag, "_row0"}, bus.cursor_row, 0);
        chk({tag, "_col0"}, bus.cursor_col, 0);
        chk({tag, "_full0"}, bus.full, 0);
    endtask

    task automatic read_cell(input string tag, input int r, input int c);
        bus.rd_row = RW'(r);
        bus.rd_col = CW'(c);
        @(posedge clk); #1;
        chk($sformatf("%s(%0d,%0d)", tag, r, c), bus.rd_data, mem[r * COLS + c]);
    endtask

    task automatic verify_all(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                read_cell(tag, r, c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [DW-1:0] old_cur;
        logic [DW-1:0] old_prev;
        int            save_pos;
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.wr_en     = 0;
        bus.wr_char   = '0;
        bus.newline   = 0;
        bus.back      = 0;
        bus.clear_req = 0;
        bus.rd_row    = '0;
        bus.rd_col    = '0;
        model_reset();

        // Reset state
        idle(3);
        chk("rst_clearing", bus.clearing, 1);
        chk("rst_row", bus.cursor_row, 0);
        chk("rst_col", bus.cursor_col, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_clear_done", bus.clear_done, 0);
        rst = 1'b1;
        wait_clear("boot", DEPTH);
        verify_all("boot_rd");

        // Row 0 filled, wrap to row 1, backspace across the row boundary
        for (int i = 0; i < COLS; i++) cmd(1, 8'h41 + DW'(i % 26), 0, 0, 0);
        cmd(0, '0, 0, 1, 0);
        read_cell("back_wrap", 0, COLS - 1);
        cmd(1, 8'h58, 0, 0, 0);
        cmd(1, 8'h51, 0, 0, 0);
        read_cell("q_cell", 1, 0);
        read_cell("last_row0", 0, COLS - 1);

        // Priority: clear wins over back and wr_en, nothing written that cycle
        save_pos   = pos;
        old_cur    = mem[save_pos];
        old_prev   = mem[save_pos - 1];
        bus.rd_row = RW'(save_pos / COLS);
        bus.rd_col = CW'(save_pos % COLS);
        cmd(1, 8'h5A, 0, 1, 1);
        @(posedge clk); #1;
        chk("prio_no_write", bus.rd_data, old_cur);
        bus.rd_row = RW'((save_pos - 1) / COLS);
        bus.rd_col = CW'((save_pos - 1) % COLS);
        @(posedge clk); #1;
        chk("prio_no_erase", bus.rd_data, old_prev);
        wait_clear("prio", DEPTH - 2);

        // Back at origin is a no-op
        cmd(0, '0, 0, 1, 0);

        // Newline from mid-row, then at the last row
        for (int i = 0; i < COLS + 5; i++) cmd(1, DW'($urandom_range(1, 255)), 0, 0, 0);
        cmd(0, '0, 1, 0, 0);
        cmd(0, '0, 1, 0, 0);
        cmd(0, '0, 1, 0, 0);
        cmd(0, '0, 0, 0, 0);
        verify_all("nl_rd");

        // Mid-sweep restart
        cmd(0, '0, 0, 0, 1);
        idle(100);
        chk("restart_still_clearing", bus.clearing, 1);
        cmd(0, '0, 0, 0, 1);
        wait_clear("restart", DEPTH);

        // Fill every cell, reject one more, backspace out of full
        for (int i = 0; i < DEPTH; i++) cmd(1, DW'($urandom_range(1, 255)), 0, 0, 0);
        cmd(1, 8'h5A, 0, 0, 0);
        cmd(0, '0, 0, 0, 0);
        read_cell("full_last", ROWS - 1, COLS - 1);
        cmd(0, '0, 1, 0, 0);
        cmd(0, '0, 0, 1, 0);
        read_cell("full_back", ROWS - 1, COLS - 1);
        verify_all("fill_rd");

        // Randomized command mix (including simultaneous commands)
        cmd(0, '0, 0, 0, 1);
        wait_clear("rand", DEPTH);
        for (int i = 0; i < 1500; i++)
            cmd($urandom_range(0, 99) < 60, DW'($urandom_range(1, 255)),
                $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15, 0);
        verify_all("rand_rd");

        // Async reset from SAVE and again mid-sweep
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_clearing", bus.clearing, 1);
        chk("arst_row", bus.cursor_row, 0);
        chk("arst_col", bus.cursor_col, 0);
        chk("arst_full", bus.full, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(50);
        #2 rst = 1'b0;
        #1;
        chk("arst_mid_clearing", bus.clearing, 1);
        chk("arst_mid_done", bus.clear_done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_clear("arst", DEPTH);
        verify_all("arst_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
